// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: oversampling constants and helpers shared by the UART receive path.
package uart_rx_pkg;
  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_A = 7;
  localparam int SAMPLE_B = 8;
  localparam int SAMPLE_C = 9;
  localparam int DATA_BITS = 8;
  typedef logic [7:0] byte_t;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line in, received byte and status pulses out.
interface uart_rx_if;
  import uart_rx_pkg::*;
  logic rxd_in;
  byte_t data_out;
  logic ready_out;
  logic framing_error_out;
  logic busy_out;
  modport slave(input rxd_in, output data_out, ready_out, framing_error_out, busy_out);
  modport master(output rxd_in, input data_out, ready_out, framing_error_out, busy_out);
endinterface

// File: rtl/uart_rx_baud_tick.sv
// uart_rx_baud_tick: free-running divider emitting one tick every DIVISOR clocks, restartable.
module uart_rx_baud_tick #(
  parameter int DIVISOR = 12
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear_in,
  output logic tick_out
);
  localparam int W = $clog2(DIVISOR);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick_out = cnt_q == W'(DIVISOR - 1);
  always_comb cnt_d = (clear_in || tick_out) ? '0 : cnt_q + W'(1);
  always_ff @(posedge clk_in)
    cnt_q <= rst_in ? '0 : cnt_d;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampled 8N1 receiver with start-bit validation and framing-error reporting.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_HZ = 1843200,
  parameter int BAUD = 9600
) (
  input logic clk_in,
  input logic rst_in,
  uart_rx_if.slave rx
);
  localparam int DIVISOR = CLK_HZ / (OVERSAMPLE * BAUD);
  if (DIVISOR < 2) begin : g_div_chk
    $error("uart_rx: DIVISOR must be at least 2");
  end
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, BRK = 3'd4;
  logic [1:0] sync_q;
  logic [2:0] state_q, state_d;
  logic [7:0] idx_q, idx_d;
  byte_t shift_q, shift_d, data_q, data_d;
  logic [1:0] samp_q, samp_d;
  logic ready_q, ready_d, ferr_q, ferr_d;
  logic rxs, tick, detect, decide, maj;
  assign rxs = sync_q[1];
  assign detect = state_q == IDLE && !rxs;
  assign decide = tick && idx_q[3:0] == 4'(SAMPLE_C);
  assign maj = maj3(samp_q[0], samp_q[1], rxs);
  uart_rx_baud_tick #(.DIVISOR(DIVISOR)) u_tick (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .clear_in(detect),
    .tick_out(tick)
  );
  // idx_q counts ticks since detection: [7:4] is the bit number, [3:0] the phase within the bit
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    data_d = data_q;
    ready_d = 1'b0;
    ferr_d = 1'b0;
    idx_d = detect ? 8'd0 : tick ? idx_q + 8'd1 : idx_q;
    samp_d[0] = (tick && idx_q[3:0] == 4'(SAMPLE_A)) ? rxs : samp_q[0];
    samp_d[1] = (tick && idx_q[3:0] == 4'(SAMPLE_B)) ? rxs : samp_q[1];
    case (state_q)
      IDLE:  state_d = rxs ? IDLE : START;
      START: state_d = decide ? (maj ? IDLE : DATA) : START;
      DATA: if (decide) begin
        shift_d = {maj, shift_q[7:1]};
        state_d = idx_q[7:4] == 4'(DATA_BITS) ? STOP : DATA;
      end
      STOP: if (decide) begin
        ready_d = maj;
        ferr_d = !maj;
        data_d = maj ? shift_q : data_q;
        state_d = maj ? IDLE : BRK;
      end
      BRK:   state_d = rxs ? IDLE : BRK;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync_q <= 2'b11;
      state_q <= IDLE;
      idx_q <= '0;
      samp_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      ready_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rx.rxd_in};
      state_q <= state_d;
      idx_q <= idx_d;
      samp_q <= samp_d;
      shift_q <= shift_d;
      data_q <= data_d;
      ready_q <= ready_d;
      ferr_q <= ferr_d;
    end
  end
  assign rx.data_out = data_q;
  assign rx.ready_out = ready_q;
  assign rx.framing_error_out = ferr_q;
  assign rx.busy_out = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed vector table plus hand sequences for latency, back-to-back, glitch, break and reset.
module tb_uart_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  uart_rx_if bus();
  uart_rx #(.CLK_HZ(3072000), .BAUD(9600)) dut (.clk_in(clk), .rst_in(rst), .rx(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] rdy_data[$];
  int rdy_cyc[$];
  int ferr_n = 0, both_n = 0, wide_n = 0, busy_rise = -1;
  logic prev_busy = 1'b0, prev_rdy = 1'b0, prev_ferr = 1'b0;
  always @(negedge clk) begin
    if (bus.ready_out === 1'b1) begin
      rdy_data.push_back(bus.data_out);
      rdy_cyc.push_back(cyc);
    end
    if (bus.framing_error_out === 1'b1) ferr_n <= ferr_n + 1;
    if (bus.ready_out === 1'b1 && bus.framing_error_out === 1'b1) both_n <= both_n + 1;
    if ((bus.ready_out === 1'b1 && prev_rdy) || (bus.framing_error_out === 1'b1 && prev_ferr))
      wide_n <= wide_n + 1;
    if (bus.busy_out === 1'b1 && !prev_busy) busy_rise <= cyc;
    prev_rdy <= bus.ready_out === 1'b1;
    prev_ferr <= bus.framing_error_out === 1'b1;
    prev_busy <= bus.busy_out === 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int bl);
    bus.rxd_in = 1'b0;
    wait_n(bl);
    for (int i = 0; i < 8; i++) begin
      bus.rxd_in = d[i];
      wait_n(bl);
    end
    bus.rxd_in = stop;
    wait_n(bl);
  endtask

  typedef struct {
    logic [7:0] d;
    int bl;
    logic stop;
    int exp_rdy;
    int exp_ferr;
    logic [7:0] exp_data;
  } vec_t;
  vec_t vecs[7];

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, f0, fall, g, old_b;
    vecs[0] = '{8'h41, 320, 1'b1, 1, 0, 8'h41};
    vecs[1] = '{8'h00, 320, 1'b1, 1, 0, 8'h00};
    vecs[2] = '{8'hFF, 320, 1'b1, 1, 0, 8'hFF};
    vecs[3] = '{8'hA5, 320, 1'b1, 1, 0, 8'hA5};
    vecs[4] = '{8'hF0, 310, 1'b1, 1, 0, 8'hF0};
    vecs[5] = '{8'hF0, 330, 1'b1, 1, 0, 8'hF0};
    vecs[6] = '{8'hC3, 320, 1'b0, 0, 1, 8'hF0};
    bus.rxd_in = 1'b1;
    rst = 1'b1;
    wait_n(4);
    chk("reset_data", bus.data_out, 8'h00);
    chk("reset_ready", bus.ready_out, 1'b0);
    chk("reset_ferr", bus.framing_error_out, 1'b0);
    chk("reset_busy", bus.busy_out, 1'b0);
    rst = 1'b0;
    wait_n(20);

    fall = cyc;
    n0 = rdy_data.size();
    f0 = ferr_n;
    send_frame(8'h41, 1'b1, 320);
    bus.rxd_in = 1'b1;
    wait_n(400);
    chk("lat_fall_to_busy", busy_rise - fall, 3);
    chk("lat_ready_count", rdy_data.size() - n0, 1);
    if (rdy_data.size() > n0) begin
      chk("lat_busy_to_ready", rdy_cyc[n0] - busy_rise, 3080);
      chk("lat_ready_data", rdy_data[n0], 8'h41);
    end
    chk("lat_no_ferr", ferr_n - f0, 0);

    for (int i = 0; i < 7; i++) begin
      n0 = rdy_data.size();
      f0 = ferr_n;
      send_frame(vecs[i].d, vecs[i].stop, vecs[i].bl);
      bus.rxd_in = 1'b1;
      wait_n(400);
      chk($sformatf("vec%0d_ready_count", i), rdy_data.size() - n0, vecs[i].exp_rdy);
      chk($sformatf("vec%0d_ferr_count", i), ferr_n - f0, vecs[i].exp_ferr);
      chk($sformatf("vec%0d_data", i), bus.data_out, vecs[i].exp_data);
      chk($sformatf("vec%0d_idle", i), bus.busy_out, 1'b0);
    end

    n0 = rdy_data.size();
    send_frame(8'h55, 1'b1, 320);
    send_frame(8'hAA, 1'b1, 320);
    bus.rxd_in = 1'b1;
    wait_n(400);
    chk("b2b_ready_count", rdy_data.size() - n0, 2);
    if (rdy_data.size() >= n0 + 2) begin
      chk("b2b_first", rdy_data[n0], 8'h55);
      chk("b2b_second", rdy_data[n0+1], 8'hAA);
    end

    old_b = busy_rise;
    n0 = rdy_data.size();
    f0 = ferr_n;
    bus.rxd_in = 1'b0;
    wait_n(100);
    bus.rxd_in = 1'b1;
    g = busy_rise;
    chk("glitch_detected", g != old_b, 1'b1);
    for (int k = 0; k < 400 && cyc < g + 199; k++) @(negedge clk);
    chk("glitch_wait", cyc, g + 199);
    chk("glitch_busy_held", bus.busy_out, 1'b1);
    @(negedge clk);
    chk("glitch_busy_drop", bus.busy_out, 1'b0);
    wait_n(300);
    chk("glitch_no_ready", rdy_data.size() - n0, 0);
    chk("glitch_no_ferr", ferr_n - f0, 0);

    n0 = rdy_data.size();
    f0 = ferr_n;
    send_frame(8'h3C, 1'b0, 320);
    wait_n(2000);
    chk("brk_busy_held", bus.busy_out, 1'b1);
    chk("brk_ferr_once", ferr_n - f0, 1);
    chk("brk_no_ready", rdy_data.size() - n0, 0);
    chk("brk_data_kept", bus.data_out, 8'hAA);
    bus.rxd_in = 1'b1;
    wait_n(400);
    chk("brk_released", bus.busy_out, 1'b0);
    send_frame(8'h7E, 1'b1, 320);
    bus.rxd_in = 1'b1;
    wait_n(400);
    chk("brk_next_data", bus.data_out, 8'h7E);
    chk("brk_next_ready", rdy_data.size() - n0, 1);
    chk("brk_ferr_total", ferr_n - f0, 1);

    n0 = rdy_data.size();
    f0 = ferr_n;
    bus.rxd_in = 1'b0;
    wait_n(320);
    for (int i = 0; i < 4; i++) begin
      bus.rxd_in = (i == 0 || i == 3);
      wait_n(320);
    end
    bus.rxd_in = 1'b1;
    wait_n(100);
    chk("rst_busy_before", bus.busy_out, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_data", bus.data_out, 8'h00);
    chk("rst_busy", bus.busy_out, 1'b0);
    chk("rst_ready", bus.ready_out, 1'b0);
    chk("rst_ferr", bus.framing_error_out, 1'b0);
    rst = 1'b0;
    wait_n(3500);
    chk("rst_no_ready", rdy_data.size() - n0, 0);
    chk("rst_no_ferr", ferr_n - f0, 0);
    send_frame(8'h12, 1'b1, 320);
    bus.rxd_in = 1'b1;
    wait_n(400);
    chk("rst_next_data", bus.data_out, 8'h12);
    chk("rst_next_ready", rdy_data.size() - n0, 1);

    chk("pulse_exclusive", both_n, 0);
    chk("pulse_width", wide_n, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
